clic_irq_arbiter: RTL and testbench



---
 rtl/clic_irq_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_clic_irq_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clic_irq_arbiter.sv
// clic_irq_arbiter
// Collects per-source pending/enable/level/privilege state, picks one winner
// per cycle (M before S, then higher level, then lower index) and offers it to
// the decode stage as a registered one-hot request. The offer is held until the
// core acknowledges it, the source stops being eligible, or a strictly better
// source appears. An acknowledge produces a one-cycle clear pulse back to the
// acknowledged source, followed by one idle cycle before re-arbitration.

module clic_irq_arbiter #(
  parameter int NumSrc = 64,
  parameter int LevelW = 8,
  localparam int IdW = $clog2(NumSrc)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumSrc-1:0]          src_pending_i,
  input  logic [NumSrc-1:0]          src_enable_i,
  input  logic [NumSrc*LevelW-1:0]   src_level_i,
  input  logic [NumSrc*2-1:0]        src_priv_i,
  output logic [NumSrc-1:0]          clic_irq_o,
  output logic [LevelW-1:0]          clic_irq_level_o,
  output logic [1:0]                 clic_irq_priv_o,
  input  logic                       irq_ack_i,
  input  logic [IdW-1:0]             irq_ack_id_i,
  output logic [NumSrc-1:0]          src_clear_o
);

  // riscv::priv_lvl_t encoding; 2'b10 is reserved and never eligible.
  localparam logic [1:0] PRIV_LVL_U = 2'b00;
  localparam logic [1:0] PRIV_LVL_S = 2'b01;
  localparam logic [1:0] PRIV_LVL_M = 2'b11;

  localparam logic [NumSrc-1:0] ONE_HOT_0 = NumSrc'(1);

  // Arbitration key: {is machine mode, level}. Comparing keys as unsigned
  // numbers gives "M before S, then higher level"; the index tie-break is
  // handled by the scan order of the selection loop.
  typedef logic [LevelW:0] key_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_ACKED = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Per-source decode
  // ---------------------------------------------------------------------------
  logic [NumSrc-1:0] elig;
  logic [LevelW-1:0] lvl_w  [NumSrc];
  logic [1:0]        priv_w [NumSrc];
  key_t              key_w  [NumSrc];

  generate
    for (genvar gi = 0; gi < NumSrc; gi++) begin : g_src
      assign lvl_w[gi]  = src_level_i[gi*LevelW +: LevelW];
      assign priv_w[gi] = src_priv_i[2*gi +: 2];
      assign elig[gi]   = src_pending_i[gi] & src_enable_i[gi] &
                          ((priv_w[gi] == PRIV_LVL_M) | (priv_w[gi] == PRIV_LVL_S));
      assign key_w[gi]  = {(priv_w[gi] == PRIV_LVL_M), lvl_w[gi]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
  logic             win_vld;
  logic [IdW-1:0]   win_id;
  key_t             win_key;
  logic [LevelW-1:0] win_level;
  logic [1:0]       win_priv;

  // Single-cycle scan from index 0 upward; a later source only takes over with
  // a strictly larger key, so the lowest index wins among equal keys.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    win_key = '0;
    for (int i = 0; i < NumSrc; i++) begin
      if (elig[i] && (!win_vld || (key_w[i] > win_key))) begin
        win_vld = 1'b1;
        win_id  = IdW'(i);
        win_key = key_w[i];
      end
    end
  end

  assign win_level = win_key[LevelW-1:0];
  assign win_priv  = priv_w[win_id];

  // ---------------------------------------------------------------------------
  // Offer state machine
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [IdW-1:0]    id_q, id_d;
  logic [NumSrc-1:0] irq_q, irq_d;
  logic [LevelW-1:0] level_q, level_d;
  logic [1:0]        priv_q, priv_d;
  logic [NumSrc-1:0] clear_q, clear_d;

  logic ack_match;
  logic offered_elig;

  assign ack_match    = irq_ack_i && (irq_ack_id_i == id_q);
  assign offered_elig = elig[id_q];

  // Next-state and next-output logic. Outputs are all registered, so every
  // branch decides what the decode stage sees in the following cycle.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    irq_d   = '0;
    level_d = '0;
    priv_d  = PRIV_LVL_U;
    clear_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_OFFER;
          id_d    = win_id;
          irq_d   = ONE_HOT_0 << win_id;
          level_d = win_level;
          priv_d  = win_priv;
        end
      end

      ST_OFFER: begin
        if (ack_match) begin
          // A matching acknowledge beats both withdraw and replace.
          state_d = ST_ACKED;
          clear_d = ONE_HOT_0 << id_q;
        end else if (!offered_elig) begin
          state_d = ST_IDLE;
        end else begin
          // The offered source is still eligible, so a winner always exists:
          // either a strictly better source or the offered one with its
          // current level/privilege.
          state_d = ST_OFFER;
          id_d    = win_id;
          irq_d   = ONE_HOT_0 << win_id;
          level_d = win_level;
          priv_d  = win_priv;
        end
      end

      ST_ACKED: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops every output at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      irq_q   <= '0;
      level_q <= '0;
      priv_q  <= PRIV_LVL_U;
      clear_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      irq_q   <= irq_d;
      level_q <= level_d;
      priv_q  <= priv_d;
      clear_q <= clear_d;
    end
  end

  assign clic_irq_o       = irq_q;
  assign clic_irq_level_o = level_q;
  assign clic_irq_priv_o  = priv_q;
  assign src_clear_o      = clear_q;

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// Bench for clic_irq_arbiter: reset behaviour, a cycle-by-cycle vector table
// for the ordered corner cases, hand-written async reset sequences and a
// randomized run against a behavioural model of the offer protocol.

module tb_clic_irq_arbiter;

  localparam int N = 64;
  localparam int PU = 0, PS = 1, PR = 2, PM = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    pend, en;
  logic [N*8-1:0]  lvl_v;
  logic [N*2-1:0]  pr_v;
  logic            ack;
  logic [5:0]      ack_id;
  logic [N-1:0]    irq, clr;
  logic [7:0]      olvl;
  logic [1:0]      opr;

  int n_pass = 0;
  int n_chk  = 0;

  clic_irq_arbiter #(.NumSrc(N), .LevelW(8)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .src_pending_i    (pend),
    .src_enable_i     (en),
    .src_level_i      (lvl_v),
    .src_priv_i       (pr_v),
    .clic_irq_o       (irq),
    .clic_irq_level_o (olvl),
    .clic_irq_priv_o  (opr),
    .irq_ack_i        (ack),
    .irq_ack_id_i     (ack_id),
    .src_clear_o      (clr)
  );

  always #5 clk = ~clk;

  // One table row = inputs held for one cycle, expected outputs after the edge.
  typedef struct {
    int s0, s1, s2;   // encoded sources, -1 = unused
    int ack_id;       // -1 = no ack
    int e_id;         // -1 = no offer
    int e_lvl;
    int e_pr;
    int e_clr;        // -1 = no clear
  } vec_t;

  vec_t tbl[$];

  function automatic int S(int id, int l, int p, int e = 1);
    return id + 64 * l + 16384 * p + 65536 * e;
  endfunction

  function automatic vec_t mk(int s0, int s1, int s2, int ack_id_v,
                              int e_id, int e_lvl, int e_pr, int e_clr);
    vec_t v;
    v.s0 = s0; v.s1 = s1; v.s2 = s2; v.ack_id = ack_id_v;
    v.e_id = e_id; v.e_lvl = e_lvl; v.e_pr = e_pr; v.e_clr = e_clr;
    return v;
  endfunction

  function automatic logic [N-1:0] oh(int id);
    logic [N-1:0] one;
    one = 1;
    return (id < 0) ? '0 : (one << id);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req)
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    else
      n_pass++;
  endtask

  task automatic clear_srcs();
    pend = '0; en = '0; lvl_v = '0; pr_v = '0;
  endtask

  task automatic add_src(input int s);
    int id, l, p, e;
    if (s < 0) return;
    id = s % 64; l = (s / 64) % 256; p = (s / 16384) % 4; e = (s / 65536) % 2;
    pend[id] = 1'b1;
    en[id]   = e[0];
    lvl_v[id*8 +: 8] = l[7:0];
    pr_v[id*2 +: 2]  = p[1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference: winner is the eligible source with the largest
  // score, where the score folds privilege, level and inverted index together.
  // ---------------------------------------------------------------------------
  int m_state;  // 0 no offer, 1 offering, 2 just acknowledged
  int m_id, m_lvl, m_pr, m_clr;

  function automatic bit is_elig(int i);
    int p;
    p = int'(pr_v[i*2 +: 2]);
    return pend[i] && en[i] && (p == PM || p == PS);
  endfunction

  function automatic int best_src();
    int best_score, score;
    best_score = -1;
    for (int i = 0; i < N; i++) begin
      if (is_elig(i)) begin
        score = ((int'(pr_v[i*2 +: 2]) == PM) ? 1 : 0) * 65536
              + int'(lvl_v[i*8 +: 8]) * 256 + (255 - i);
        if (score > best_score) best_score = score;
      end
    end
    return (best_score < 0) ? -1 : 255 - (best_score % 256);
  endfunction

  task automatic model_offer(input int w);
    m_state = 1;
    m_id  = w;
    m_lvl = int'(lvl_v[w*8 +: 8]);
    m_pr  = int'(pr_v[w*2 +: 2]);
  endtask

  task automatic model_step();
    int w;
    m_clr = -1;
    case (m_state)
      0: begin
        w = best_src();
        if (w >= 0) model_offer(w);
      end
      1: begin
        if (ack && int'(ack_id) == m_id) begin
          m_state = 2;
          m_clr = m_id;
        end else if (!is_elig(m_id)) begin
          m_state = 0;
        end else begin
          model_offer(best_src());
        end
      end
      default: m_state = 0;
    endcase
  endtask

  initial begin
    int r;
    bit got;
    rst = 1'b1; ack = 1'b0; ack_id = '0;
    clear_srcs();
    add_src(S(5, 10, PM));

    // Reset: outputs quiet while reset is held, offer one cycle after release.
    tick(); tick();
    chk("reset irq",   64'(irq), 64'(0));
    chk("reset level", 64'(olvl), 64'(0));
    chk("reset priv",  64'(opr), 64'(0));
    chk("reset clear", 64'(clr), 64'(0));
    rst = 1'b0;
    tick();
    chk("post-reset irq",   64'(irq), 64'(oh(5)));
    chk("post-reset level", 64'(olvl), 64'(10));
    chk("post-reset priv",  64'(opr), 64'(PM));

    // Vector table, applied one row per cycle starting from the src 5 offer.
    tbl.push_back(mk(-1, -1, -1, -1,                              -1, 0, 0, -1));
    tbl.push_back(mk(S(3,200,PS), S(9,1,PM), -1, -1,               9, 1, PM, -1));
    tbl.push_back(mk(S(3,200,PS), S(9,1,PM), S(2,1,PM), -1,        2, 1, PM, -1));
    tbl.push_back(mk(-1, -1, -1, -1,                              -1, 0, 0, -1));
    tbl.push_back(mk(-1, -1, -1, -1,                              -1, 0, 0, -1));
    tbl.push_back(mk(S(7,50,PM), -1, -1, -1,                       7, 50, PM, -1));
    tbl.push_back(mk(S(7,50,PM), -1, -1, 4,                        7, 50, PM, -1));
    tbl.push_back(mk(S(7,50,PM), -1, -1, 7,                       -1, 0, 0, 7));
    tbl.push_back(mk(S(7,50,PM), -1, -1, -1,                      -1, 0, 0, -1));
    tbl.push_back(mk(S(7,50,PM), -1, -1, -1,                       7, 50, PM, -1));
    tbl.push_back(mk(S(12,60,PM), -1, -1, -1,                     -1, 0, 0, -1));
    tbl.push_back(mk(S(12,60,PM), -1, -1, -1,                     12, 60, PM, -1));
    tbl.push_back(mk(S(12,60,PM,0), -1, -1, 12,                   -1, 0, 0, 12));
    tbl.push_back(mk(S(12,60,PM), -1, -1, -1,                     -1, 0, 0, -1));
    tbl.push_back(mk(S(12,60,PM), -1, -1, -1,                     12, 60, PM, -1));
    tbl.push_back(mk(S(12,60,PM,0), -1, -1, -1,                   -1, 0, 0, -1));
    tbl.push_back(mk(S(20,255,PU), -1, -1, -1,                    -1, 0, 0, -1));
    tbl.push_back(mk(S(20,255,PU), S(21,255,PR), -1, -1,          -1, 0, 0, -1));
    tbl.push_back(mk(S(20,255,PU), S(22,0,PS), -1, -1,            22, 0, PS, -1));
    tbl.push_back(mk(S(22,9,PS), -1, -1, -1,                      22, 9, PS, -1));
    tbl.push_back(mk(S(22,5,PS), S(30,5,PS), -1, -1,              22, 5, PS, -1));
    tbl.push_back(mk(S(22,5,PS), S(10,5,PS), -1, -1,              10, 5, PS, -1));
    tbl.push_back(mk(S(22,5,PS), S(10,1,PS), -1, -1,              22, 5, PS, -1));
    tbl.push_back(mk(S(22,5,PS), S(40,255,PM), S(10,1,PS), 22,    -1, 0, 0, 22));
    tbl.push_back(mk(S(63,255,PM), S(0,254,PM), -1, -1,           -1, 0, 0, -1));
    tbl.push_back(mk(S(63,255,PM), S(0,254,PM), -1, -1,           63, 255, PM, -1));
    tbl.push_back(mk(S(63,255,PM), S(0,255,PM), -1, -1,            0, 255, PM, -1));

    for (int i = 0; i < tbl.size(); i++) begin
      clear_srcs();
      add_src(tbl[i].s0); add_src(tbl[i].s1); add_src(tbl[i].s2);
      ack    = (tbl[i].ack_id >= 0);
      ack_id = (tbl[i].ack_id >= 0) ? 6'(tbl[i].ack_id) : 6'd0;
      tick();
      chk($sformatf("row%0d irq", i),   64'(irq),  64'(oh(tbl[i].e_id)));
      chk($sformatf("row%0d level", i), 64'(olvl), 64'(tbl[i].e_lvl));
      chk($sformatf("row%0d priv", i),  64'(opr),  64'(tbl[i].e_pr));
      chk($sformatf("row%0d clear", i), 64'(clr),  64'(oh(tbl[i].e_clr)));
    end
    ack = 1'b0; ack_id = '0;

    // Async reset while offering: outputs drop without waiting for an edge.
    clear_srcs();
    add_src(S(33, 7, PM));
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      tick();
      got = (irq == oh(33));
    end
    chk("offer33 before reset", 64'(irq), 64'(oh(33)));
    #2 rst = 1'b1;
    #1;
    chk("async reset offer irq",   64'(irq), 64'(0));
    chk("async reset offer level", 64'(olvl), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Async reset while acknowledged: the clear pulse is cut short.
    clear_srcs();
    add_src(S(7, 3, PS));
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      tick();
      got = (irq == oh(7));
    end
    chk("offer7 before ack", 64'(irq), 64'(oh(7)));
    ack = 1'b1; ack_id = 6'd7;
    tick();
    ack = 1'b0;
    chk("acked clear", 64'(clr), 64'(oh(7)));
    #1 rst = 1'b1;
    #1;
    chk("async reset acked clear", 64'(clr), 64'(0));
    chk("async reset acked irq",   64'(irq), 64'(0));

    // Randomized run against the model, starting from reset.
    clear_srcs();
    m_state = 0; m_id = 0; m_lvl = 0; m_pr = 0; m_clr = -1;
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        r = int'($urandom_range(0, N - 1));
        pend[r] = ($urandom_range(0, 1) == 1);
        en[r]   = ($urandom_range(0, 3) != 0);
        lvl_v[r*8 +: 8] = 8'($urandom_range(0, 3) * 85);
        pr_v[r*2 +: 2]  = 2'($urandom_range(0, 3));
      end
      ack = ($urandom_range(0, 3) == 0);
      if (m_state == 1 && $urandom_range(0, 1) == 1)
        ack_id = 6'(m_id);
      else
        ack_id = 6'($urandom_range(0, N - 1));
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("rnd%0d irq", c),   64'(irq), 64'((m_state == 1) ? oh(m_id) : '0));
      chk($sformatf("rnd%0d level", c), 64'(olvl), 64'((m_state == 1) ? m_lvl : 0));
      chk($sformatf("rnd%0d priv", c),  64'(opr), 64'((m_state == 1) ? m_pr : 0));
      chk($sformatf("rnd%0d clear", c), 64'(clr), 64'(oh(m_clr)));
      chk($sformatf("rnd%0d onehot0", c), 64'($onehot0(irq)), 64'(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
